tdc_pulse_pair_gen: RTL and testbench

TDC_PULSE_PAIR_GEN -- requirements
Module: tdc_pulse_pair_gen

---
 rtl/tdc_pulse_pair_gen.sv | 158 +++++++++++++++
 tb/tb_tdc_pulse_pair_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_pulse_pair_gen.sv
// rtl/tdc_pulse_pair_gen.sv - START/STOP pulse pair generator for TDC stimulus
module tdc_pulse_pair_gen #(
   parameter int CNT_W = 16,
   parameter int PW_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             arm,
   input  logic [CNT_W-1:0] delay_cycles,
   input  logic [PW_W-1:0]  pulse_width,
   input  logic [CNT_W-1:0] period_cycles,
   input  logic [CNT_W-1:0] burst_count,
   output logic             tdc_start,
   output logic             tdc_stop,
   output logic             busy,
   output logic             done,
   output logic             cfg_error,
   output logic [31:0]      pairs_sent
);

   // Phase arithmetic is one bit wider than the fields so D+W+1 never overflows.
   localparam int TW = CNT_W + 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            r_state;
   logic [TW-1:0]     r_t;
   logic [TW-1:0]     r_d;
   logic [TW-1:0]     r_w;
   logic [TW-1:0]     r_dw;
   logic [TW-1:0]     r_p;
   logic [CNT_W-1:0]  r_b;
   logic [CNT_W-1:0]  r_pair_cnt;
   logic              r_start;
   logic              r_stop;
   logic              r_busy;
   logic              r_done;
   logic              r_cfg_error;
   logic [31:0]       r_pairs_sent;

   // Configuration as seen at arm time: zero width counts as one cycle.
   logic [TW-1:0]     w_d_ext;
   logic [TW-1:0]     w_w_eff;
   logic [TW-1:0]     w_p_ext;
   logic [TW-1:0]     w_d_plus_w;
   logic [TW-1:0]     w_min_p;
   logic              w_cfg_ok;
   logic              w_accept;

   assign w_d_ext    = {1'b0, delay_cycles};
   assign w_w_eff    = (pulse_width == '0) ? TW'(1) : TW'(pulse_width);
   assign w_p_ext    = {1'b0, period_cycles};
   assign w_d_plus_w = w_d_ext + w_w_eff;
   assign w_min_p    = w_d_plus_w + TW'(1);
   assign w_cfg_ok   = (w_d_ext >= w_w_eff) && (w_p_ext >= w_min_p);
   assign w_accept   = (r_state == S_IDLE) && enable && arm;

   // Running phase: outputs are registered from the phase value being loaded.
   logic [TW-1:0]     w_t_next;
   logic              w_wrap;
   logic              w_last;
   logic              w_start_next;
   logic              w_stop_next;
   logic              w_stop_fall;

   assign w_wrap       = (r_t == (r_p - TW'(1)));
   assign w_last       = (r_b != '0) && (r_pair_cnt == r_b);
   assign w_t_next     = w_wrap ? '0 : (r_t + TW'(1));
   assign w_start_next = (w_t_next < r_w);
   assign w_stop_next  = (w_t_next >= r_d) && (w_t_next < r_dw);
   assign w_stop_fall  = r_stop && !w_stop_next;

   assign tdc_start  = r_start;
   assign tdc_stop   = r_stop;
   assign busy       = r_busy;
   assign done       = r_done;
   assign cfg_error  = r_cfg_error;
   assign pairs_sent = r_pairs_sent;

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_t          <= '0;
         r_d          <= '0;
         r_w          <= '0;
         r_dw         <= '0;
         r_p          <= '0;
         r_b          <= '0;
         r_pair_cnt   <= '0;
         r_start      <= 1'b0;
         r_stop       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cfg_error  <= 1'b0;
         r_pairs_sent <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_cfg_ok) begin
                     // First START rises on the accepting edge; D>=W>=1 keeps STOP low at t=0.
                     r_state      <= S_RUN;
                     r_t          <= '0;
                     r_d          <= w_d_ext;
                     r_w          <= w_w_eff;
                     r_dw         <= w_d_plus_w;
                     r_p          <= w_p_ext;
                     r_b          <= burst_count;
                     r_pair_cnt   <= '0;
                     r_pairs_sent <= '0;
                     r_start      <= 1'b1;
                     r_stop       <= 1'b0;
                     r_busy       <= 1'b1;
                     r_cfg_error  <= 1'b0;
                  end else begin
                     r_cfg_error  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (!enable) begin
                  // Abort: no done, pair count frozen even if STOP is cut short.
                  r_state <= S_IDLE;
                  r_t     <= '0;
                  r_start <= 1'b0;
                  r_stop  <= 1'b0;
                  r_busy  <= 1'b0;
               end else if (w_wrap && w_last) begin
                  r_state <= S_IDLE;
                  r_t     <= '0;
                  r_start <= 1'b0;
                  r_stop  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_t     <= w_t_next;
                  r_start <= w_start_next;
                  r_stop  <= w_stop_next;
                  if (w_stop_fall) begin
                     r_pairs_sent <= r_pairs_sent + 32'd1;
                     r_pair_cnt   <= r_pair_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_start <= 1'b0;
               r_stop  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_pulse_pair_gen.sv
// tb/tb_tdc_pulse_pair_gen.sv - scoreboard bench for tdc_pulse_pair_gen
module tb_tdc_pulse_pair_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        arm = 1'b0;
   logic [15:0] delay_cycles = '0;
   logic [7:0]  pulse_width = '0;
   logic [15:0] period_cycles = '0;
   logic [15:0] burst_count = '0;
   logic        tdc_start, tdc_stop, busy, done, cfg_error;
   logic [31:0] pairs_sent;

   tdc_pulse_pair_gen dut (
      .clk(clk), .rst(rst), .enable(enable), .arm(arm),
      .delay_cycles(delay_cycles), .pulse_width(pulse_width),
      .period_cycles(period_cycles), .burst_count(burst_count),
      .tdc_start(tdc_start), .tdc_stop(tdc_stop), .busy(busy),
      .done(done), .cfg_error(cfg_error), .pairs_sent(pairs_sent)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int rise; int width;} ev_t;
   ev_t q_start[$];
   ev_t q_stop[$];
   ev_t q_done[$];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cmp_ev(input string name, inout ev_t q[$], input int rise, input int width);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         failures++;
         $display("FAIL %s unexpected pulse rise=%0d width=%0d expected none", name, rise, width);
      end else begin
         e = q.pop_front();
         if (e.rise != rise || e.width != width) begin
            failures++;
            $display("FAIL %s actual rise=%0d width=%0d expected rise=%0d width=%0d",
                     name, rise, width, e.rise, e.width);
         end
      end
   endtask

   // Monitor: measures every pulse on START, STOP and done and pops the scoreboard.
   logic p_start = 1'b0, p_stop = 1'b0, p_done = 1'b0;
   int   r_start_at, r_stop_at, r_done_at;
   always @(negedge clk) begin
      if (rst) begin
         p_start = 1'b0; p_stop = 1'b0; p_done = 1'b0;
      end else begin
         if (done && busy) begin
            checks++; failures++;
            $display("FAIL done_busy_overlap actual=1 expected=0");
         end
         if (tdc_start && !p_start) r_start_at = cyc;
         if (!tdc_start && p_start) cmp_ev("start_pulse", q_start, r_start_at, cyc - r_start_at);
         if (tdc_stop && !p_stop) r_stop_at = cyc;
         if (!tdc_stop && p_stop) cmp_ev("stop_pulse", q_stop, r_stop_at, cyc - r_stop_at);
         if (done && !p_done) r_done_at = cyc;
         if (!done && p_done) cmp_ev("done_pulse", q_done, r_done_at, cyc - r_done_at);
         p_start = tdc_start; p_stop = tdc_stop; p_done = done;
      end
   end

   int last_n;

   // Apply a configuration with an arm pulse; expected pulses go to the scoreboard.
   task automatic do_burst(input int d, input int w, input int p, input int b,
                           input int npairs, input bit with_done);
      int weff;
      @(negedge clk);
      delay_cycles = 16'(d); pulse_width = 8'(w);
      period_cycles = 16'(p); burst_count = 16'(b);
      arm = 1'b1;
      last_n = cyc + 1;
      weff = (w == 0) ? 1 : w;
      for (int k = 0; k < npairs; k++) begin
         q_start.push_back('{last_n + k*p, weff});
         q_stop.push_back('{last_n + k*p + d, weff});
      end
      if (with_done) q_done.push_back('{last_n + npairs*p, 1});
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++; failures++;
         $display("FAIL %s timeout busy=1 expected=0", name);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("rst_start", tdc_start, 0);
      chk("rst_stop", tdc_stop, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_error", cfg_error, 0);
      chk("rst_pairs", pairs_sent, 0);
      @(negedge clk); rst = 1'b0; enable = 1'b1;
      repeat (2) @(negedge clk);

      // Basic burst: D=5 W=2 P=10 B=3.
      do_burst(5, 2, 10, 3, 3, 1);
      chk("b1_busy", busy, 1);
      chk("b1_start_t0", tdc_start, 1);
      wait_idle("b1_idle");
      chk("b1_pairs", pairs_sent, 3);
      chk("b1_cfg_error", cfg_error, 0);

      // Zero width treated as one cycle.
      do_burst(1, 0, 3, 1, 1, 1);
      wait_idle("b2_idle");
      chk("b2_pairs", pairs_sent, 1);

      // Illegal configurations: D<W, then P < D+W+1.
      do_burst(3, 4, 20, 1, 0, 0);
      repeat (3) @(negedge clk);
      chk("ill1_cfg_error", cfg_error, 1);
      chk("ill1_busy", busy, 0);
      chk("ill1_start", tdc_start, 0);
      chk("ill1_stop", tdc_stop, 0);
      do_burst(5, 2, 7, 1, 0, 0);
      repeat (3) @(negedge clk);
      chk("ill2_cfg_error", cfg_error, 1);
      chk("ill2_busy", busy, 0);
      chk("ill2_pairs_held", pairs_sent, 1);
      do_burst(2, 1, 4, 2, 2, 1);
      chk("legal_clears_cfg_error", cfg_error, 0);
      wait_idle("b3_idle");
      chk("b3_pairs", pairs_sent, 2);

      // Arm while disabled is ignored, even with an illegal configuration.
      @(negedge clk);
      enable = 1'b0; delay_cycles = 16'd3; pulse_width = 8'd4; arm = 1'b1;
      @(negedge clk); arm = 1'b0;
      @(negedge clk);
      chk("dis_arm_busy", busy, 0);
      chk("dis_arm_cfg_error", cfg_error, 0);
      enable = 1'b1;

      // Continuous mode aborted by enable after 50 cycles.
      do_burst(2, 1, 8, 0, 7, 0);
      while (cyc < last_n + 50) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_start", tdc_start, 0);
      chk("abort_stop", tdc_stop, 0);
      chk("abort_pairs", pairs_sent, 6);
      repeat (3) @(negedge clk);
      chk("abort_pairs_hold", pairs_sent, 6);
      enable = 1'b1;

      // Mid-burst input changes and re-arm have no effect.
      do_burst(5, 2, 10, 2, 2, 1);
      repeat (3) @(negedge clk);
      delay_cycles = 16'd1; pulse_width = 8'd7; period_cycles = 16'd3; burst_count = 16'd9;
      arm = 1'b1;
      @(negedge clk); arm = 1'b0;
      wait_idle("b4_idle");
      chk("b4_pairs", pairs_sent, 2);

      // Asynchronous reset while STOP is high.
      do_burst(5, 2, 10, 3, 3, 1);
      while (cyc < last_n + 5) @(negedge clk);
      chk("rst_mid_stop_high", tdc_stop, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_stop", tdc_stop, 0);
      chk("arst_start", tdc_start, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_pairs", pairs_sent, 0);
      q_start.delete(); q_stop.delete(); q_done.delete();
      @(negedge clk);
      chk("arst_held_busy", busy, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      do_burst(1, 1, 3, 1, 1, 1);
      wait_idle("b5_idle");
      chk("b5_pairs", pairs_sent, 1);
      chk("b5_cfg_error", cfg_error, 0);

      chk("q_start_empty", q_start.size(), 0);
      chk("q_stop_empty", q_stop.size(), 0);
      chk("q_done_empty", q_done.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
